// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared widths, cosine table and rounding helpers for the 8x8 IDCT
package idct_pkg;

    localparam int DEF_IN_W  = 12;
    localparam int DEF_MID_W = 16;
    localparam int DEF_OUT_W = 8;
    localparam int COEF_FRAC = 12;
    localparam int COEF_W    = COEF_FRAC + 2;
    localparam int CALC_W    = 40;

    localparam logic signed [CALC_W-1:0] HALF_LSB = CALC_W'(1) << (COEF_FRAC - 1);

    // COS_TAB[k][n] = round(2^12 * 0.5 * c(k) * cos((2n+1)k*pi/16))
    localparam logic signed [COEF_W-1:0] COS_TAB [8][8] = '{
        '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
        '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009},
        '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892},
        '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703},
        '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
        '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138},
        '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784},
        '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400}
    };

    function automatic logic signed [CALC_W-1:0] round_frac(input logic signed [CALC_W-1:0] acc);
        return (acc + HALF_LSB) >>> COEF_FRAC;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_signed(input logic signed [CALC_W-1:0] v,
                                                            input int w);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (CALC_W'(1) << (w - 1)) - CALC_W'(1);
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

    function automatic logic signed [CALC_W-1:0] clamp_unsigned(input logic signed [CALC_W-1:0] v,
                                                                input int w);
        logic signed [CALC_W-1:0] hi;
        hi = (CALC_W'(1) << w) - CALC_W'(1);
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        return v;
    endfunction

endpackage

// File: rtl/idct_1d.sv
// rtl/idct_1d.sv - combinational 8-point IDCT with signed-saturate or unsigned-clamp output
module idct_1d import idct_pkg::*; #(
    parameter int IW      = DEF_IN_W,
    parameter int OW      = DEF_MID_W,
    parameter int ACC_W   = DEF_IN_W + COEF_FRAC + 5,
    parameter bit CLAMP_U = 1'b0
) (
    input  logic [8*IW-1:0] in_vec,
    output logic [8*OW-1:0] out_vec
);

    logic signed [ACC_W-1:0]  acc [8];
    logic signed [CALC_W-1:0] rnd [8];

    // out[n] = sum_k C[k][n] * in[k], rounded back to integer scale
    always_comb begin
        out_vec = '0;
        for (int n = 0; n < 8; n++) begin
            acc[n] = '0;
            for (int k = 0; k < 8; k++) begin
                acc[n] = acc[n] + ACC_W'(COS_TAB[k][n]) * ACC_W'($signed(in_vec[k*IW +: IW]));
            end
            rnd[n] = round_frac(CALC_W'(acc[n]));
            if (CLAMP_U)
                out_vec[n*OW +: OW] = OW'(clamp_unsigned(rnd[n], OW));
            else
                out_vec[n*OW +: OW] = OW'(sat_signed(rnd[n], OW));
        end
    end

endmodule

// File: rtl/full_idct.sv
// rtl/full_idct.sv - 8x8 2D IDCT: row pass, ping-pong transpose buffer, column read engine
module full_idct import idct_pkg::*; #(
    parameter int IN_W  = DEF_IN_W,
    parameter int MID_W = DEF_MID_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8*IN_W-1:0] data_in,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [8*OUT_W-1:0] data_out,
    output logic              out_valid,
    output logic [2:0]        out_col,
    output logic              out_sob,
    output logic [14:0]       cnt_in,
    output logic [14:0]       cnt_out,
    output logic              err_sync
);

    localparam int ROW_ACC_W = IN_W + COEF_FRAC + 5;
    localparam int COL_ACC_W = MID_W + COEF_FRAC + 5;

    logic [8*MID_W-1:0] mid_vec;
    logic [8*MID_W-1:0] rd_vec;
    logic [8*OUT_W-1:0] pix_vec;

    logic [MID_W-1:0] mem [2][8][8];

    logic [2:0] row_cnt;
    logic [2:0] row_idx;
    logic       wbank;
    logic       blk_done;
    logic       rd_active;
    logic       rd_bank;
    logic [2:0] rd_col;
    logic       s1_valid;
    logic [2:0] s1_col;

    idct_1d #(.IW(IN_W), .OW(MID_W), .ACC_W(ROW_ACC_W), .CLAMP_U(1'b0)) u_row (
        .in_vec (data_in),
        .out_vec(mid_vec)
    );

    idct_1d #(.IW(MID_W), .OW(OUT_W), .ACC_W(COL_ACC_W), .CLAMP_U(1'b1)) u_col (
        .in_vec (rd_vec),
        .out_vec(pix_vec)
    );

    // A start-of-frame row always lands in slot 0, even mid-block
    assign row_idx  = in_sof ? 3'd0 : row_cnt;
    assign blk_done = in_valid && (row_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int x = 0; x < 8; x++) begin
                mem[wbank][row_idx][x] <= mid_vec[x*MID_W +: MID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt   <= '0;
            wbank     <= 1'b0;
            cnt_in    <= '0;
            err_sync  <= 1'b0;
            rd_active <= 1'b0;
            rd_bank   <= 1'b0;
            rd_col    <= '0;
            rd_vec    <= '0;
            s1_valid  <= 1'b0;
            s1_col    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_sob   <= 1'b0;
            cnt_out   <= '0;
        end else begin
            err_sync <= 1'b0;
            if (in_valid) begin
                if (in_sof && (row_cnt != 3'd0)) begin
                    err_sync <= 1'b1;
                    row_cnt  <= 3'd1;
                end else if (blk_done) begin
                    row_cnt <= 3'd0;
                    wbank   <= ~wbank;
                    cnt_in  <= cnt_in + 15'd1;
                end else begin
                    row_cnt <= row_idx + 3'd1;
                end
            end

            // Stage 1: fetch one transposed column from the bank being drained
            for (int v = 0; v < 8; v++) begin
                rd_vec[v*MID_W +: MID_W] <= mem[rd_bank][v][rd_col];
            end
            s1_valid <= rd_active;
            s1_col   <= rd_col;

            // A block completing on the last read cycle restarts the engine with no bubble
            if (blk_done) begin
                rd_active <= 1'b1;
                rd_bank   <= wbank;
                rd_col    <= 3'd0;
            end else if (rd_active) begin
                if (rd_col == 3'd7)
                    rd_active <= 1'b0;
                rd_col <= rd_col + 3'd1;
            end

            // Stage 2: column pass result registered to the outputs
            out_valid <= s1_valid;
            out_sob   <= s1_valid && (s1_col == 3'd0);
            if (s1_valid) begin
                data_out <= pix_vec;
                out_col  <= s1_col;
                if (s1_col == 3'd7)
                    cnt_out <= cnt_out + 15'd1;
            end
        end
    end

endmodule

// File: tb/tb_full_idct.sv
// tb/tb_full_idct.sv - self-checking bench for full_idct against an arithmetic IDCT model
module tb_full_idct;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [63:0] data_out;
    logic        out_valid;
    logic [2:0]  out_col;
    logic        out_sob;
    logic [14:0] cnt_in;
    logic [14:0] cnt_out;
    logic        err_sync;

    full_idct dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_col  (out_col),
        .out_sob  (out_sob),
        .cnt_in   (cnt_in),
        .cnt_out  (cnt_out),
        .err_sync (err_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          col;
        logic        sob;
        logic [63:0] data;
    } obs_t;

    int   cyc = 0;
    obs_t out_q[$];
    int   exp_q[$];
    int   tl_q[$];
    int   err_cnt = 0;
    int   blk[8][8];
    int   ctab[8][8];
    int   last_obs[8][8];
    int   fexp[8][8];
    int   last_t;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) out_q.push_back('{cyc, int'(out_col), out_sob, data_out});
        if (err_sync) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic real cfac(input int k, input int n);
        real ck;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        return 0.5 * ck * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    endfunction

    function automatic int rnd_real(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic longint rsh(input longint a);
        return (a + 2048) >>> 12;
    endfunction

    // Integer reference: row pass then column pass, pixels queued column-major
    task automatic model_block();
        longint mid[8][8];
        longint acc;
        for (int v = 0; v < 8; v++)
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int u = 0; u < 8; u++) acc += longint'(ctab[u][x]) * blk[v][u];
                acc = rsh(acc);
                mid[v][x] = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
            end
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                acc = 0;
                for (int v = 0; v < 8; v++) acc += longint'(ctab[v][y]) * mid[v][x];
                acc = rsh(acc);
                exp_q.push_back((acc < 0) ? 0 : (acc > 255) ? 255 : int'(acc));
            end
    endtask

    task automatic send_row(input int v, input bit sof);
        for (int u = 0; u < 8; u++) data_in[u*12 +: 12] = blk[v][u][11:0];
        in_valid = 1'b1;
        in_sof   = sof;
        @(negedge clk);
        last_t   = cyc;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_block(input int gmax, input bit sof_first);
        model_block();
        for (int v = 0; v < 8; v++) begin
            send_row(v, sof_first && (v == 0));
            if (v < 7) repeat ($urandom_range(gmax, 0)) @(negedge clk);
        end
        tl_q.push_back(last_t);
    endtask

    task automatic set_dc(input int val);
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) blk[v][u] = 0;
        blk[0][0] = val;
    endtask

    task automatic set_rand(input bit full);
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++)
                blk[v][u] = full ? int'($urandom_range(4095, 0)) - 2048 : int'($urandom_range(160, 0)) - 80;
        if (!full) blk[0][0] = int'($urandom_range(2047, 0)) - 200;
    endtask

    task automatic check_blocks(input int n);
        int   w;
        int   t0;
        obs_t e;
        w = 0;
        while (out_q.size() < n * 8 && w < 60 * n + 60) begin
            @(negedge clk);
            w++;
        end
        chk("drain", out_q.size() >= n * 8, 1);
        for (int b = 0; b < n; b++) begin
            if (tl_q.size() == 0) break;
            t0 = tl_q.pop_front() + 2;
            for (int x = 0; x < 8; x++) begin
                if (out_q.size() == 0) break;
                e = out_q.pop_front();
                chk("out_col", e.col, x);
                chk("out_sob", e.sob, x == 0);
                chk("timing", e.cyc, t0 + x);
                for (int y = 0; y < 8; y++) begin
                    last_obs[x][y] = int'(e.data[y*8 +: 8]);
                    chk("pixel", e.data[y*8 +: 8], exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out_q.delete();
        exp_q.delete();
        tl_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        int   w;
        real  p;
        int   d;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) ctab[k][n] = rnd_real(4096.0 * cfac(k, n));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_sob", out_sob, 0);
        chk("rst_cnt_in", cnt_in, 0);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_err_sync", err_sync, 0);
        reset = 1'b0;
        @(negedge clk);

        // DC only
        set_dc(1024);
        send_block(0, 1'b1);
        check_blocks(1);
        chk("dc_128", last_obs[3][5], 128);
        chk("dc_cnt_in", cnt_in, 1);
        chk("dc_cnt_out", cnt_out, 1);

        // Clamping both ways
        set_dc(2047);
        send_block(0, 1'b1);
        check_blocks(1);
        chk("clamp_hi", last_obs[7][7], 255);
        set_dc(-1024);
        send_block(0, 1'b0);
        check_blocks(1);
        chk("clamp_lo", last_obs[0][0], 0);

        // Back-to-back full-rate blocks
        set_dc(1024);
        send_block(0, 1'b1);
        set_dc(512);
        send_block(0, 1'b0);
        set_dc(0);
        send_block(0, 1'b0);
        check_blocks(3);
        chk("b2b_zero", last_obs[4][2], 0);
        chk("b2b_cnt_in", cnt_in, 6);
        chk("b2b_cnt_out", cnt_out, 6);

        // Same block gap-free and with 0-3 idle cycles between rows
        set_rand(1'b0);
        send_block(0, 1'b0);
        send_block(3, 1'b0);
        check_blocks(2);

        // Random blocks, mixed gaps, plus one full-range block
        for (int i = 0; i < 4; i++) begin
            set_rand(1'b0);
            send_block(2, i == 0);
        end
        set_rand(1'b1);
        send_block(0, 1'b0);
        check_blocks(5);
        chk("rand_cnt_in", cnt_in, 13);
        chk("rand_cnt_out", cnt_out, 13);

        // Resync: truncated block followed by a full DC block
        do_reset();
        set_rand(1'b0);
        for (int v = 0; v < 4; v++) send_row(v, v == 0);
        set_dc(1024);
        send_block(0, 1'b1);
        repeat (12) @(negedge clk);
        check_blocks(1);
        chk("resync_pix", last_obs[6][1], 128);
        chk("resync_err_cnt", err_cnt, 1);
        chk("resync_extra_out", out_q.size(), 0);
        chk("resync_cnt_in", cnt_in, 1);
        chk("resync_cnt_out", cnt_out, 1);

        // Reset during column 3 of a read
        set_rand(1'b0);
        send_block(0, 1'b0);
        w = 0;
        while (!(out_valid && out_col == 3'd3) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("mid_read_found", w < 50, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_cnt_in", cnt_in, 0);
        chk("mid_rst_cnt_out", cnt_out, 0);
        reset = 1'b0;
        out_q.delete();
        exp_q.delete();
        tl_q.delete();
        @(negedge clk);

        // Next block against both the integer model and a floating-point golden IDCT
        set_dc(800);
        blk[0][1] = 40;
        blk[1][0] = -30;
        blk[1][1] = 20;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                p = 0.0;
                for (int v = 0; v < 8; v++)
                    for (int u = 0; u < 8; u++) p += cfac(v, y) * cfac(u, x) * real'(blk[v][u]);
                d = rnd_real(p);
                fexp[x][y] = (d < 0) ? 0 : (d > 255) ? 255 : d;
            end
        send_block(1, 1'b1);
        check_blocks(1);
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                d = last_obs[x][y] - fexp[x][y];
                chk("float_golden", (d >= -1) && (d <= 1), 1);
            end
        chk("post_rst_cnt_in", cnt_in, 1);
        chk("post_rst_cnt_out", cnt_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/full_idct.md
Name: full_idct

Overview:
- 2D 8x8 inverse DCT; the decode-side counterpart of the forward full-DCT pipeline.
- Accepts one row of 8 signed 12-bit coefficients per cycle and returns 8x8 reconstructed 8-bit pixels.
- Row pass feeds a ping-pong transpose buffer; the column pass follows.
- Output is column-major: one pixel column per cycle.

Parameters:
- IN_W, 12, signed coefficient width per element.
- MID_W, 16, signed width of row-pass results held in the transpose buffer.
- COEF_FRAC, 12, fractional bits of the cosine table; table entries are signed COEF_FRAC+2 bits.
- OUT_W, 8, unsigned pixel width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8*IN_W  coefficient row v. Element u is at [u*IN_W +: IN_W]; u=0 is DC.
- in_valid  in  1  data_in is accepted this cycle.
- in_sof  in  1  with in_valid, marks row 0 of a new block.
- data_out  out  8*OUT_W  pixel column x. Element y is at [y*OUT_W +: OUT_W].
- out_valid  out  1  data_out is valid.
- out_col  out  3  column index x of data_out.
- out_sob  out  1  high with out_col==0.
- cnt_in  out  15  blocks fully accepted, wraps at 2^15.
- cnt_out  out  15  blocks fully emitted, wraps at 2^15.
- err_sync  out  1  one-cycle pulse when in_sof truncates a partial block.

Behaviour:
- Reset (synchronous): all outputs 0; row counter 0; write bank 0; read engine idle; any partial or in-flight block is discarded. Buffer contents are not cleared.
- No backpressure. Rows may arrive with gaps. The row counter advances only on in_valid.
- Row pass (combinational), per accepted row v, for each x:
  - acc = sum_u C[u][x]*F[u]
  - mid = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, saturated to signed MID_W
  - written to write bank, location [v][x], at the accepting edge.
- Cosine table: C[k][n] = round(2^COEF_FRAC * 0.5*c(k)*cos((2n+1)k*pi/16)), with c(0)=1/sqrt2 and c(k>0)=1. Orthonormal, so C[0][n]=1448.
- Row counter hits 7 on an accepted row: bank swaps, cnt_in increments, read engine starts on the filled bank.
- Read engine: 8 consecutive cycles, x=0..7. Each cycle:
  - reads mid[v][x] for v=0..7
  - column pass, same rounding
  - clamps to 0..255
  - registers result.
- Latency: row 7 accepted at edge T → out_col 0 valid after edge T+2. Columns 1..7 follow on consecutive cycles. cnt_out increments on the edge that retires column 7.
- Streaming: the writer needs at least 8 cycles per block and the reader always finishes in 8, so the banks never collide. Full-rate back-to-back blocks give continuous out_valid.
- in_sof with in_valid while row counter != 0:
  - the row is taken as row 0 of a new block
  - the partial block is abandoned; cnt_in is unchanged
  - err_sync pulses on the next cycle.
- in_sof at row counter 0: normal, no error.
- in_sof deasserted on row 0 is legal; blocks are also delimited by counting.
- Simultaneous row-7 accept and read completion on the other bank: both proceed. The new read starts the next cycle with no bubble.
- Accumulators: signed IN_W+COEF_FRAC+5 bits in the row pass and MID_W+COEF_FRAC+5 bits in the column pass. No intermediate overflow.

Decomposition:
- Shared package idct_pkg holds:
  - the 8x8 cosine table as localparam constants
  - COEF_W
  - rounding and saturation helper functions
  - default widths.
- One sub-module, idct_1d:
  - combinational 8-point IDCT
  - parameterised input and output widths
  - output mode: signed saturate or unsigned clamp
  - instantiated twice, row pass and column pass.
- Ping-pong buffer, counters and read engine live in full_idct.

Test Plan:
- DC only: F00=1024, all else 0 → 8 columns, every pixel 128; out_sob on column 0; cnt_in=cnt_out=1.
- Clamping: F00=2047 → all pixels 255. F00=-1024 → all pixels 0.
- Back-to-back: 3 blocks at full rate, each with a distinct DC value (1024, 512, 0) → 24 contiguous out_valid cycles with values 128, 64, 0. First output after edge T+2 of row 7.
- Gapped input: rows separated by 0-3 idle cycles → identical pixels to the gap-free run; output starts 2 edges after the last row.
- Resync: in_sof at row 4 of a block, then a full DC=1024 block → err_sync pulses once; only one block is emitted (all 128); cnt_in=1.
- Reset mid-read: reset asserted during column 3 → out_valid low next cycle, all counters 0. The next full block reconstructs correctly versus a floating-point IDCT golden model, max error ±1 LSB per pixel.
